// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared types and constants for the data-memory controller.
//   mem_size_t    - access size strobe from the control unit
//   dmem_state_t  - controller FSM states
//   BE_*          - base byte-enable patterns, shifted by the byte offset
//   addr_misaligned() - alignment rule shared by the FSM
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        byte_size     = 2'd0,
        halfword_size = 2'd1,
        word_size     = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } dmem_state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic addr_misaligned(input mem_size_t size, input logic [1:0] off);
        logic res;
        res = 1'b0;
        case (size)
            halfword_size: res = off[0];
            word_size:     res = (off != 2'b00);
            default:       res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: handshaked memory bus between dmem_ctrl and the interconnect.
//   bus_req_valid/ready - request handshake
//   bus_req_addr/we/be/wdata - request fields (word address, byte enables)
//   bus_rsp_valid/data  - read data or write acknowledge
interface dmem_ctrl_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_req_addr;
    logic        bus_req_we;
    logic [3:0]  bus_req_be;
    logic [31:0] bus_req_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_data;

    modport master (
        output bus_req_valid, bus_req_addr, bus_req_we, bus_req_be, bus_req_wdata,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_data
    );

    modport slave (
        input  bus_req_valid, bus_req_addr, bus_req_we, bus_req_be, bus_req_wdata,
        output bus_req_ready, bus_rsp_valid, bus_rsp_data
    );
endinterface

// File: rtl/dmem_ctrl_lsu_align.sv
// lsu_align: purely combinational lane logic for loads and stores.
//   i_size, i_addr_lo  - access size and byte offset within the word
//   i_wr_data          - store data (low bytes significant)
//   i_rsp_data         - raw read word from the bus
//   i_zero_extend      - 1 = zero-extend loads, 0 = sign-extend
//   o_be, o_wdata      - byte enables and lane-replicated store data
//   o_rd_data          - selected and extended load result
module lsu_align
    import dmem_ctrl_pkg::*;
(
    input  mem_size_t   i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wr_data,
    input  logic [31:0] i_rsp_data,
    input  logic        i_zero_extend,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rd_data
);
    logic [7:0]  w_lane [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_lane[gi] = i_rsp_data[8*gi +: 8];
    end

    // Halfword lane is chosen by addr[1] only; addr[0] is zero when aligned.
    assign w_byte = w_lane[i_addr_lo];
    assign w_half = {w_lane[{i_addr_lo[1], 1'b1}], w_lane[{i_addr_lo[1], 1'b0}]};

    always_comb begin
        o_be      = BE_WORD;
        o_wdata   = i_wr_data;
        o_rd_data = i_rsp_data;
        case (i_size)
            byte_size: begin
                o_be      = BE_BYTE << i_addr_lo;
                o_wdata   = {4{i_wr_data[7:0]}};
                o_rd_data = i_zero_extend ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            halfword_size: begin
                o_be      = BE_HALF << i_addr_lo;
                o_wdata   = {2{i_wr_data[15:0]}};
                o_rd_data = i_zero_extend ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: sequences one core data access onto the handshaked memory bus.
//   clk, reset            - clock, synchronous active-high reset
//   dmem_req/wr_en/size/zero_extend/addr/wr_data - access from the core
//   dmem_rd_data, misaligned, bus_err - results, valid only in DONE
//   stall                 - holds the core until DONE
//   bus                   - memory bus master port
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_req,
    input  logic        dmem_wr_en,
    input  mem_size_t   dmem_size,
    input  logic        dmem_zero_extend,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wr_data,
    output logic [31:0] dmem_rd_data,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    dmem_ctrl_if.master bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // Last WAIT_RSP cycle index; reaching it without a response aborts.
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    dmem_state_t r_state, w_state_next;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr, r_wdata, r_rd_data;
    mem_size_t     r_size;
    logic          r_we, r_zext, r_mis, r_err;

    logic          w_mis_in, w_timeout, w_in_req, w_in_done;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_load_data;

    assign w_mis_in  = addr_misaligned(dmem_size, dmem_addr[1:0]);
    assign w_timeout = (r_cnt == TMO_LAST);
    assign w_in_req  = (r_state == REQ);
    assign w_in_done = (r_state == DONE);

    lsu_align u_align (
        .i_size        (r_size),
        .i_addr_lo     (r_addr[1:0]),
        .i_wr_data     (r_wdata),
        .i_rsp_data    (bus.bus_rsp_data),
        .i_zero_extend (r_zext),
        .o_be          (w_be),
        .o_wdata       (w_wdata),
        .o_rd_data     (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_size    <= byte_size;
            r_we      <= 1'b0;
            r_zext    <= 1'b0;
            r_rd_data <= '0;
            r_mis     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (dmem_req) begin
                        r_addr    <= dmem_addr;
                        r_wdata   <= dmem_wr_data;
                        r_size    <= dmem_size;
                        r_we      <= dmem_wr_en;
                        r_zext    <= dmem_zero_extend;
                        r_mis     <= w_mis_in;
                        r_err     <= 1'b0;
                        r_rd_data <= '0;
                    end
                end
                // Held at zero while requesting so WAIT_RSP always starts at 0.
                REQ: r_cnt <= '0;
                WAIT_RSP: begin
                    if (bus.bus_rsp_valid) begin
                        r_rd_data <= r_we ? 32'd0 : w_load_data;
                    end else if (w_timeout) begin
                        r_err     <= 1'b1;
                        r_rd_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        case (r_state)
            IDLE: begin
                if (dmem_req) begin
                    stall        = 1'b1;
                    w_state_next = w_mis_in ? DONE : REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus.bus_req_ready) w_state_next = WAIT_RSP;
            end
            WAIT_RSP: begin
                stall = 1'b1;
                // A response arriving on the timeout cycle still completes normally.
                if (bus.bus_rsp_valid || w_timeout) w_state_next = DONE;
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.bus_req_valid = w_in_req;
    assign bus.bus_req_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign bus.bus_req_we    = w_in_req & r_we;
    assign bus.bus_req_be    = w_in_req ? w_be : 4'd0;
    assign bus.bus_req_wdata = w_in_req ? w_wdata : 32'd0;

    assign dmem_rd_data = w_in_done ? r_rd_data : 32'd0;
    assign misaligned   = w_in_done & r_mis;
    assign bus_err      = w_in_done & r_err;
endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dmem_req = 1'b0;
    logic        dmem_wr_en = 1'b0;
    mem_size_t   dmem_size = byte_size;
    logic        dmem_zero_extend = 1'b0;
    logic [31:0] dmem_addr = 32'd0;
    logic [31:0] dmem_wr_data = 32'd0;
    logic [31:0] dmem_rd_data;
    logic        stall, misaligned, bus_err;

    int checks = 0;
    int errors = 0;

    dmem_ctrl_if bus_if ();

    always #5 clk = ~clk;

    dmem_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk              (clk),
        .reset            (reset),
        .dmem_req         (dmem_req),
        .dmem_wr_en       (dmem_wr_en),
        .dmem_size        (dmem_size),
        .dmem_zero_extend (dmem_zero_extend),
        .dmem_addr        (dmem_addr),
        .dmem_wr_data     (dmem_wr_data),
        .dmem_rd_data     (dmem_rd_data),
        .stall            (stall),
        .misaligned       (misaligned),
        .bus_err          (bus_err),
        .bus              (bus_if.master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic bit model_mis(input int sz, input logic [31:0] a);
        if (sz == 1) return a[0];
        if (sz == 2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_be(input int sz, input logic [31:0] a);
        int off = int'(a % 4);
        if (sz == 0) return 4'(1 << off);
        if (sz == 1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] d);
        if (sz == 0) return (d & 32'hFF) * 32'h01010101;
        if (sz == 1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input int sz, input bit zx, input logic [31:0] a,
                                               input logic [31:0] raw);
        int off = int'(a % 4);
        logic [31:0] v;
        if (sz == 0) begin
            v = (raw >> (8 * off)) & 32'hFF;
            if (!zx && v >= 32'h80) v = v - 32'h100;
        end else if (sz == 1) begin
            v = (raw >> (8 * (off / 2) * 2)) & 32'hFFFF;
            if (!zx && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = raw;
        end
        return v;
    endfunction

    // One complete access, starting just after a falling edge with the FSM in IDLE.
    // rsp_dly = number of WAIT_RSP cycles before the response; >= TMO means none.
    task automatic access(input string name, input bit wr, input int sz, input bit zx,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int rdy_dly, input int rsp_dly, input logic [31:0] raw);
        bit          mis = model_mis(sz, addr);
        bit          tmo = !mis && (rsp_dly >= TMO);
        int          exp_stall = mis ? 1 : (2 + rdy_dly + (tmo ? TMO : rsp_dly + 1));
        logic [31:0] exp_rd = (mis || wr || tmo) ? 32'd0 : model_load(sz, zx, addr, raw);
        int          stalls = 0, vcyc = 0, w = 0, busy_nz = 0;
        bit          waiting = 0, done = 0;

        dmem_req = 1'b1; dmem_wr_en = wr; dmem_size = mem_size_t'(2'(sz));
        dmem_zero_extend = zx; dmem_addr = addr; dmem_wr_data = wdata;
        for (int cyc = 0; cyc < 4 * TMO + 40 && !done; cyc++) begin
            #1;
            bus_if.bus_req_ready = 1'b0;
            bus_if.bus_rsp_valid = 1'($urandom_range(0, 1));   // ignored outside WAIT_RSP
            bus_if.bus_rsp_data  = $urandom;
            if (bus_if.bus_req_valid) begin
                check({name, "_addr"}, bus_if.bus_req_addr, addr & 32'hFFFF_FFFC);
                check({name, "_be"}, 32'(bus_if.bus_req_be), 32'(model_be(sz, addr)));
                check({name, "_we"}, 32'(bus_if.bus_req_we), 32'(wr));
                if (wr) check({name, "_wdata"}, bus_if.bus_req_wdata, model_wdata(sz, wdata));
                if (vcyc == rdy_dly) begin
                    bus_if.bus_req_ready = 1'b1;
                    waiting = 1; w = 0;
                end
                vcyc++;
            end else if (waiting) begin
                bus_if.bus_rsp_valid = (w == rsp_dly);
                bus_if.bus_rsp_data  = raw;
                if (w == rsp_dly || w == TMO - 1) waiting = 0;
                w++;
            end
            #1;
            if (stall) begin
                stalls++;
                if (dmem_rd_data != 0 || misaligned || bus_err) busy_nz++;
            end else begin
                done = 1;
                check({name, "_rd"}, dmem_rd_data, exp_rd);
                check({name, "_mis"}, 32'(misaligned), 32'(mis));
                check({name, "_err"}, 32'(bus_err), 32'(tmo));
                check({name, "_done_bus"}, 32'(bus_if.bus_req_valid) | bus_if.bus_req_addr
                      | bus_if.bus_req_wdata | {27'd0, bus_if.bus_req_we, bus_if.bus_req_be}, 32'd0);
            end
            @(negedge clk);
        end
        check({name, "_done_seen"}, 32'(done), 32'd1);
        check({name, "_stalls"}, 32'(stalls), 32'(exp_stall));
        check({name, "_valid_cycles"}, 32'(vcyc), mis ? 32'd0 : 32'(rdy_dly + 1));
        check({name, "_busy_outs"}, 32'(busy_nz), 32'd0);
        bus_if.bus_req_ready = 1'b0;
        bus_if.bus_rsp_valid = 1'b0;
        $display("access %s wr=%0d sz=%0d zx=%0d addr=%h rdy=%0d rsp=%0d stalls=%0d rd=%h",
                 name, wr, sz, zx, addr, rdy_dly, rsp_dly, stalls, dmem_rd_data);
    endtask

    // One cycle with no request: everything must read 0 and stall stays low.
    task automatic idle_cycle(input string name);
        dmem_req = 1'b0;
        dmem_addr = $urandom;
        #1;
        bus_if.bus_req_ready = 1'($urandom_range(0, 1));
        bus_if.bus_rsp_valid = 1'($urandom_range(0, 1));
        bus_if.bus_rsp_data  = $urandom;
        #1;
        check({name, "_stall"}, 32'(stall), 32'd0);
        check({name, "_outs"}, dmem_rd_data | {30'd0, misaligned, bus_err}, 32'd0);
        check({name, "_bus"}, 32'(bus_if.bus_req_valid) | bus_if.bus_req_addr
              | bus_if.bus_req_wdata | {27'd0, bus_if.bus_req_we, bus_if.bus_req_be}, 32'd0);
        @(negedge clk);
        bus_if.bus_req_ready = 1'b0;
        bus_if.bus_rsp_valid = 1'b0;
        $display("idle %s", name);
    endtask

    initial begin
        bus_if.bus_req_ready = 1'b0;
        bus_if.bus_rsp_valid = 1'b1;   // stale response during reset
        bus_if.bus_rsp_data  = 32'hCAFEF00D;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bus_if.bus_rsp_valid = 1'b0;
        idle_cycle("reset_state");

        access("lw_100", 0, 2, 0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
        access("lb_103", 0, 0, 0, 32'h103, 32'h0, 0, 0, 32'h80FF_0000);
        access("lbu_103", 0, 0, 1, 32'h103, 32'h0, 0, 0, 32'h80FF_0000);
        access("sh_202", 1, 1, 0, 32'h202, 32'h1234ABCD, 0, 0, 32'h5555_AAAA);
        access("lw_101_mis", 0, 2, 0, 32'h101, 32'h0, 0, 0, 32'h0);
        access("sh_203_mis", 1, 1, 0, 32'h203, 32'h1234, 0, 0, 32'h0);
        access("lh_102", 0, 1, 0, 32'h102, 32'h0, 1, 2, 32'h9234_0001);
        access("lhu_102", 0, 1, 1, 32'h102, 32'h0, 0, 1, 32'h9234_0001);
        access("sb_301", 1, 0, 0, 32'h301, 32'hFFFF_FF5A, 2, 0, 32'h0);
        access("lw_tmo", 0, 2, 0, 32'h400, 32'h0, 5, TMO + 3, 32'h1111_2222);
        access("lw_rsp_last", 0, 2, 0, 32'h404, 32'h0, 0, TMO - 1, 32'h3333_4444);
        access("sw_tmo", 1, 2, 0, 32'h408, 32'h7777_8888, 1, TMO, 32'h0);
        idle_cycle("after_tmo");

        // Reset while waiting for a response, then a stale response in IDLE.
        dmem_req = 1'b1; dmem_wr_en = 1'b0; dmem_size = word_size;
        dmem_zero_extend = 1'b0; dmem_addr = 32'h300; dmem_wr_data = 32'h0;
        #2; check("rst_idle_stall", 32'(stall), 32'd1);
        @(negedge clk);
        #1; bus_if.bus_req_ready = 1'b1;
        #1; check("rst_req_valid", 32'(bus_if.bus_req_valid), 32'd1);
        @(negedge clk);
        bus_if.bus_req_ready = 1'b0;
        #2; check("rst_wait_stall", 32'(stall), 32'd1);
        @(negedge clk);
        reset = 1'b1; dmem_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_data = 32'hABAD_1DEA;
        #2;
        check("rst_stale_stall", 32'(stall), 32'd0);
        check("rst_stale_outs", dmem_rd_data | {30'd0, misaligned, bus_err}, 32'd0);
        check("rst_stale_valid", 32'(bus_if.bus_req_valid), 32'd0);
        @(negedge clk);
        bus_if.bus_rsp_valid = 1'b0;
        $display("reset during WAIT_RSP with stale response");
        idle_cycle("after_stale");
        access("lw_after_rst", 0, 2, 0, 32'h300, 32'h0, 0, 0, 32'h0BAD_F00D);

        // Randomized accesses, some back to back, some separated by idle cycles.
        for (int n = 0; n < 40; n++) begin
            int          sz = $urandom_range(0, 2);
            bit          wr = 1'($urandom_range(0, 1));
            bit          zx = 1'($urandom_range(0, 1));
            logic [31:0] a = $urandom;
            int          rdy = $urandom_range(0, 3);
            int          r = $urandom_range(0, 9);
            int          rsp;
            if ($urandom_range(0, 3) != 0) a = a & ~(sz == 2 ? 32'd3 : (sz == 1 ? 32'd1 : 32'd0));
            rsp = (r < 7) ? $urandom_range(0, 3) : (r == 7 ? TMO - 1 : (r == 8 ? TMO : TMO + 5));
            access($sformatf("rnd%0d", n), wr, sz, zx, a, $urandom, rdy, rsp, $urandom);
            if ($urandom_range(0, 2) == 0) idle_cycle($sformatf("rnd%0d_gap", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Sequences the data-memory accesses decoded by the control unit onto a handshaked memory bus. Accepts the single-cycle core's `dmem_req`/`dmem_wr_en`/`dmem_size`/`dmem_zero_extend` strobes and stalls the core until the access completes. Generates byte enables, replicates store data across lanes, and aligns and extends load data. Sits between the core datapath and the memory interconnect.

## Interface
Clock: `clk`, single clock. Reset: `reset`, synchronous, active-high.

Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum `WAIT_RSP` cycles before the access is aborted with `bus_err`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `dmem_req` in 1: access request from the control unit.
- `dmem_wr_en` in 1: 1 = store, 0 = load.
- `dmem_size` in `mem_size_t`: access size, one of `byte_size`, `halfword_size`, `word_size`.
- `dmem_zero_extend` in 1: load extension; 1 = zero-extend, 0 = sign-extend.
- `dmem_addr` in 32: byte address from the ALU.
- `dmem_wr_data` in 32: store data; the low bytes are significant.
- `dmem_rd_data` out 32: aligned and extended load result.
- `stall` out 1: core must hold PC and its inputs.
- `misaligned` out 1: alignment-fault flag for the current access.
- `bus_err` out 1: timeout flag for the current access.
- `bus_req_valid` out 1: bus request valid.
- `bus_req_ready` in 1: bus request accepted.
- `bus_req_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `bus_req_we` out 1: bus write enable.
- `bus_req_be` out 4: byte enables.
- `bus_req_wdata` out 32: lane-replicated store data.
- `bus_rsp_valid` in 1: response or write acknowledge.
- `bus_rsp_data` in 32: raw read word.

## Operation
- FSM states: `IDLE`, `REQ`, `WAIT_RSP`, `DONE`.
- `IDLE`, `dmem_req=1`:
  - Latch address, size, write enable, zero-extend and write data.
  - If misaligned (half with `addr[0]=1`, or word with `addr[1:0]≠0`), go to `DONE` with `misaligned_q=1` and no bus activity.
  - Otherwise go to `REQ`.
- `REQ`: drive `bus_req_valid=1` from the latched fields. On `bus_req_ready=1`, go to `WAIT_RSP`.
- `WAIT_RSP`:
  - On `bus_rsp_valid=1`, capture data (loads only) and go to `DONE`.
  - If the counter reaches `TIMEOUT_CYCLES`, set `bus_err_q=1`, set load result 0, go to `DONE`.
- `DONE`: go to `IDLE` unconditionally.
- `stall` is combinational:
  - 1 in `IDLE` when `dmem_req=1`.
  - 1 in `REQ` and `WAIT_RSP`.
  - 0 in `DONE`.
  - 0 in `IDLE` without a request.
  - The core commits the instruction at the `DONE` clock edge.
- `dmem_rd_data`, `misaligned`, `bus_err`:
  - Registered values, valid only in `DONE`; 0 in all other states.
  - Stores return `dmem_rd_data=0`.
- Byte enables:
  - Byte: `4'b0001<<addr[1:0]`.
  - Half: `4'b0011<<addr[1:0]`.
  - Word: `4'b1111`.
- Store data replication:
  - Byte: `{4{wdata[7:0]}}`.
  - Half: `{2{wdata[15:0]}}`.
  - Word: as is.
- Load data:
  - Select the lane at `addr[1:0]` (byte) or `addr[1]` (half).
  - Extend to 32 bits per `dmem_zero_extend`; word loads pass through.
- Ignored inputs:
  - `bus_rsp_valid` outside `WAIT_RSP` is ignored, including stale responses after reset.
  - `dmem_req` in `REQ`, `WAIT_RSP` and `DONE` is ignored.

## Timing
- Reset: state `IDLE`, timeout counter 0.
- Reset values of outputs:
  - `bus_req_valid` = 0.
  - `bus_req_addr`, `bus_req_be`, `bus_req_wdata`, `bus_req_we` = 0.
  - `dmem_rd_data` = 0.
  - `misaligned` = 0, `bus_err` = 0.
  - `stall` = 0 unless `dmem_req=1`.
- Bus fields are driven from registers. They are nonzero only in `REQ`, held stable until ready, and 0 elsewhere.
- Latency with zero-wait bus: `IDLE`(stall) → `REQ`(ready=1) → `WAIT_RSP`(rsp=1) → `DONE`. That is 3 stall cycles, commit on the 4th edge.
- Misaligned access: 1 stall cycle, then `DONE`.
- The earliest legal response is the cycle after the request handshake.
- Counter behaviour:
  - Clears on entry to `WAIT_RSP`.
  - Increments each `WAIT_RSP` cycle without a response.
  - When response and timeout coincide, the response wins.
- No timeout applies in `REQ`; `bus_req_valid` is never dropped before `bus_req_ready`.
- Back-to-back accesses: `DONE` → `IDLE` → new request; minimum 4 cycles per access.
- `reset` mid-access: `IDLE` on the next edge. The outstanding transaction is abandoned and its response ignored.

## Structure
- `risc_pkg` additions:
  - `dmem_state_t` (the four states).
  - `BE_BYTE`, `BE_HALF`, `BE_WORD` base byte-enable constants.
  - Reuses the existing `mem_size_t`.
- One combinational sub-module, `lsu_align`:
  - Byte-enable generation, store replication, load lane select and extension.
  - Two instances are not needed; a single shared instance is driven from the latched fields.
- The FSM, timeout counter and latches stay in `dmem_ctrl`.

## Test plan
- Word load, `addr=0x100`, `bus_req_ready` and `bus_rsp_valid` asserted at first opportunity, `rsp_data=0xDEADBEEF`:
  - Expect `bus_req_addr=0x100`, `be=1111`.
  - Expect `stall` high exactly 3 cycles and `dmem_rd_data=0xDEADBEEF` in `DONE`.
- `LB` at `addr=0x103`, `rsp_data=0x80FF_0000` → `be=1000`, `dmem_rd_data=0xFFFFFF80`.
- `LBU` at the same address → `0x00000080`.
- `SH` at `addr=0x202`, `wdata=0x1234ABCD` → `be=1100`, `bus_req_wdata=0xABCDABCD`, `we=1`, `dmem_rd_data=0`.
- `LW` at `addr=0x101` → no `bus_req_valid` ever, `misaligned=1` for one cycle, stall 1 cycle.
- `bus_req_ready` low 5 cycles:
  - Valid and fields held stable for the 5 cycles.
  - Then ready=1, no response for `TIMEOUT_CYCLES`.
  - Expect `bus_err=1`, `dmem_rd_data=0`, return to `IDLE`.
- `reset` asserted during `WAIT_RSP`, then `bus_rsp_valid=1` in the following `IDLE` cycle:
  - Expect the response ignored and all outputs 0.
  - A new request completes normally afterwards.
